// File: rtl/control_sequencer_pkg.sv
// Shared opcode, ALU-code and state definitions for the control sequencer.
package control_sequencer_pkg;

  // Instruction opcodes (ir[31:27])
  localparam logic [4:0] OP_ADD  = 5'd0;
  localparam logic [4:0] OP_SUB  = 5'd1;
  localparam logic [4:0] OP_AND  = 5'd2;
  localparam logic [4:0] OP_OR   = 5'd3;
  localparam logic [4:0] OP_SHR  = 5'd4;
  localparam logic [4:0] OP_SHRA = 5'd5;
  localparam logic [4:0] OP_SHL  = 5'd6;
  localparam logic [4:0] OP_ROR  = 5'd7;
  localparam logic [4:0] OP_ROL  = 5'd8;
  localparam logic [4:0] OP_MUL  = 5'd15;
  localparam logic [4:0] OP_DIV  = 5'd16;
  localparam logic [4:0] OP_NOP  = 5'd25;
  localparam logic [4:0] OP_HALT = 5'd26;

  // ALU operation codes driven on ALUop
  localparam logic [3:0] ALU_ADD  = 4'd0;
  localparam logic [3:0] ALU_SUB  = 4'd1;
  localparam logic [3:0] ALU_AND  = 4'd2;
  localparam logic [3:0] ALU_OR   = 4'd3;
  localparam logic [3:0] ALU_SHR  = 4'd5;
  localparam logic [3:0] ALU_SHRA = 4'd6;
  localparam logic [3:0] ALU_SHL  = 4'd7;
  localparam logic [3:0] ALU_ROR  = 4'd8;
  localparam logic [3:0] ALU_ROL  = 4'd9;
  localparam logic [3:0] ALU_MUL  = 4'd10;
  localparam logic [3:0] ALU_DIV  = 4'd11;

  // Sequencer states
  typedef enum logic [3:0] {
    S_IDLE   = 4'd0,
    S_T0     = 4'd1,
    S_T1     = 4'd2,
    S_T2     = 4'd3,
    S_T3     = 4'd4,
    S_T4     = 4'd5,
    S_T5     = 4'd6,
    S_T6     = 4'd7,
    S_HALTED = 4'd8
  } state_t;

endpackage

// File: rtl/control_sequencer_opcode_decoder.sv
// Combinational opcode classifier: ALU code plus instruction-class flags.
module control_sequencer_opcode_decoder
  import control_sequencer_pkg::*;
(
  input  logic [4:0] i_opcode,
  output logic [3:0] o_alu_op,
  output logic       o_is_alu,
  output logic       o_is_muldiv,
  output logic       o_is_halt
);

  // Map opcode to ALU code; anything not listed is treated as a no-op
  always_comb begin
    o_alu_op    = ALU_ADD;
    o_is_alu    = 1'b1;
    o_is_muldiv = 1'b0;
    o_is_halt   = 1'b0;
    case (i_opcode)
      OP_ADD:  o_alu_op = ALU_ADD;
      OP_SUB:  o_alu_op = ALU_SUB;
      OP_AND:  o_alu_op = ALU_AND;
      OP_OR:   o_alu_op = ALU_OR;
      OP_SHR:  o_alu_op = ALU_SHR;
      OP_SHRA: o_alu_op = ALU_SHRA;
      OP_SHL:  o_alu_op = ALU_SHL;
      OP_ROR:  o_alu_op = ALU_ROR;
      OP_ROL:  o_alu_op = ALU_ROL;
      OP_MUL: begin
        o_alu_op    = ALU_MUL;
        o_is_muldiv = 1'b1;
      end
      OP_DIV: begin
        o_alu_op    = ALU_DIV;
        o_is_muldiv = 1'b1;
      end
      OP_HALT: begin
        o_is_alu  = 1'b0;
        o_is_halt = 1'b1;
      end
      default: o_is_alu = 1'b0;
    endcase
  end

endmodule

// File: rtl/control_sequencer.sv
// Multi-cycle datapath control sequencer: fetch (T0-T2), ALU execute (T3-T6).
module control_sequencer
  import control_sequencer_pkg::*;
#(
  parameter int NREGS = 16
) (
  input  logic             clock,
  input  logic             clear,
  input  logic             start,
  input  logic             mem_ready,
  input  logic [31:0]      ir,
  output logic             PCout,
  output logic             PCin,
  output logic             IncPC,
  output logic             MARin,
  output logic             Read,
  output logic             MDRin,
  output logic             MDRout,
  output logic             IRin,
  output logic             Yin,
  output logic             Zlowin,
  output logic             Zhighin,
  output logic             Zlowout,
  output logic             Zhighout,
  output logic             HIin,
  output logic             LOin,
  output logic [NREGS-1:0] Rin,
  output logic [NREGS-1:0] Rout,
  output logic [3:0]       ALUop,
  output logic             run,
  output logic             halted
);

  state_t      r_state;
  state_t      w_state_next;
  logic [31:15] r_ir;
  logic [4:0]  w_dec_opcode;
  logic [3:0]  w_alu_op;
  logic        w_is_alu;
  logic        w_is_muldiv;
  logic        w_is_halt;
  logic        w_unused;

  // Operand fields below bit 15 carry no control information
  assign w_unused = ^ir[14:0];

  // One-hot register select; indices wrap when NREGS is below 16
  function automatic logic [NREGS-1:0] reg_sel(input logic [3:0] idx);
    reg_sel = {{(NREGS-1){1'b0}}, 1'b1} << (32'(idx) % NREGS);
  endfunction

  // T2 branches on the word being loaded; later states use the latched copy
  assign w_dec_opcode = (r_state == S_T2) ? ir[31:27] : r_ir[31:27];

  control_sequencer_opcode_decoder u_opcode_decoder (
    .i_opcode    (w_dec_opcode),
    .o_alu_op    (w_alu_op),
    .o_is_alu    (w_is_alu),
    .o_is_muldiv (w_is_muldiv),
    .o_is_halt   (w_is_halt)
  );

  // State register with asynchronous clear to IDLE
  always_ff @(posedge clock or negedge clear) begin
    if (!clear) r_state <= S_IDLE;
    else        r_state <= w_state_next;
  end

  // Capture the instruction word as it is loaded into IR at the end of T2
  always_ff @(posedge clock or negedge clear) begin
    if (!clear)                r_ir <= '0;
    else if (r_state == S_T2)  r_ir <= ir[31:15];
  end

  // Next-state and strobe decode
  always_comb begin
    w_state_next = r_state;
    PCout    = 1'b0;
    PCin     = 1'b0;
    IncPC    = 1'b0;
    MARin    = 1'b0;
    Read     = 1'b0;
    MDRin    = 1'b0;
    MDRout   = 1'b0;
    IRin     = 1'b0;
    Yin      = 1'b0;
    Zlowin   = 1'b0;
    Zhighin  = 1'b0;
    Zlowout  = 1'b0;
    Zhighout = 1'b0;
    HIin     = 1'b0;
    LOin     = 1'b0;
    Rin      = '0;
    Rout     = '0;
    ALUop    = 4'd0;
    run      = (r_state != S_IDLE) && (r_state != S_HALTED);
    halted   = (r_state == S_HALTED);
    case (r_state)
      S_IDLE: begin
        if (start) w_state_next = S_T0;
      end
      S_T0: begin
        PCout        = 1'b1;
        MARin        = 1'b1;
        IncPC        = 1'b1;
        Zlowin       = 1'b1;
        w_state_next = S_T1;
      end
      S_T1: begin
        Read  = 1'b1;
        MDRin = 1'b1;
        // Incremented PC is written back only on the completing cycle
        if (mem_ready) begin
          Zlowout      = 1'b1;
          PCin         = 1'b1;
          w_state_next = S_T2;
        end
      end
      S_T2: begin
        MDRout = 1'b1;
        IRin   = 1'b1;
        if (w_is_halt)     w_state_next = S_HALTED;
        else if (w_is_alu) w_state_next = S_T3;
        else               w_state_next = S_T0;
      end
      S_T3: begin
        Rout         = reg_sel(r_ir[22:19]);
        Yin          = 1'b1;
        w_state_next = S_T4;
      end
      S_T4: begin
        Rout         = reg_sel(r_ir[18:15]);
        ALUop        = w_alu_op;
        Zlowin       = 1'b1;
        Zhighin      = w_is_muldiv;
        w_state_next = S_T5;
      end
      S_T5: begin
        Zlowout = 1'b1;
        if (w_is_muldiv) begin
          LOin         = 1'b1;
          w_state_next = S_T6;
        end else begin
          Rin          = reg_sel(r_ir[26:23]);
          w_state_next = S_T0;
        end
      end
      S_T6: begin
        Zhighout     = 1'b1;
        HIin         = 1'b1;
        w_state_next = S_T0;
      end
      S_HALTED: w_state_next = S_HALTED;
      default:  w_state_next = S_IDLE;
    endcase
  end

endmodule

// File: tb/tb_control_sequencer.sv
// Self-checking bench: per-cycle expected strobes queued at drive time, popped at negedge.
module tb_control_sequencer;

  typedef struct packed {
    logic        run;
    logic        halted;
    logic        PCout;
    logic        PCin;
    logic        IncPC;
    logic        MARin;
    logic        Read;
    logic        MDRin;
    logic        MDRout;
    logic        IRin;
    logic        Yin;
    logic        Zlowin;
    logic        Zhighin;
    logic        Zlowout;
    logic        Zhighout;
    logic        HIin;
    logic        LOin;
    logic [15:0] Rin;
    logic [15:0] Rout;
    logic [3:0]  ALUop;
  } outs_t;

  typedef struct {
    logic        s;
    logic        mr;
    logic [31:0] irv;
    outs_t       e;
  } vec_t;

  logic        clock = 1'b0;
  logic        clear = 1'b0;
  logic        start = 1'b0;
  logic        mem_ready = 1'b0;
  logic [31:0] ir = 32'h0;

  logic PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin;
  logic Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, run, halted;
  logic [15:0] Rin, Rout;
  logic [3:0]  ALUop;

  outs_t act;
  outs_t exp_q[$];
  vec_t  vecs[$];
  int    checks = 0;
  int    errors = 0;
  int    pcin_seen = 0;

  always #5 clock = ~clock;

  control_sequencer #(.NREGS(16)) dut (
    .clock(clock), .clear(clear), .start(start), .mem_ready(mem_ready), .ir(ir),
    .PCout(PCout), .PCin(PCin), .IncPC(IncPC), .MARin(MARin),
    .Read(Read), .MDRin(MDRin), .MDRout(MDRout), .IRin(IRin),
    .Yin(Yin), .Zlowin(Zlowin), .Zhighin(Zhighin), .Zlowout(Zlowout),
    .Zhighout(Zhighout), .HIin(HIin), .LOin(LOin),
    .Rin(Rin), .Rout(Rout), .ALUop(ALUop), .run(run), .halted(halted)
  );

  assign act = {run, halted, PCout, PCin, IncPC, MARin, Read, MDRin, MDRout, IRin,
                Yin, Zlowin, Zhighin, Zlowout, Zhighout, HIin, LOin, Rin, Rout, ALUop};

  // Expected strobe patterns per state
  function automatic outs_t o_zero();
    outs_t e = '0;
    return e;
  endfunction
  function automatic outs_t o_t0();
    outs_t e = '0;
    e.run = 1; e.PCout = 1; e.MARin = 1; e.IncPC = 1; e.Zlowin = 1;
    return e;
  endfunction
  function automatic outs_t o_t1(input logic mr);
    outs_t e = '0;
    e.run = 1; e.Read = 1; e.MDRin = 1; e.PCin = mr; e.Zlowout = mr;
    return e;
  endfunction
  function automatic outs_t o_t2();
    outs_t e = '0;
    e.run = 1; e.MDRout = 1; e.IRin = 1;
    return e;
  endfunction
  function automatic outs_t o_t3(input int rb);
    outs_t e = '0;
    e.run = 1; e.Rout = 16'(1) << rb; e.Yin = 1;
    return e;
  endfunction
  function automatic outs_t o_t4(input int rc, input logic [3:0] alu, input bit md);
    outs_t e = '0;
    e.run = 1; e.Rout = 16'(1) << rc; e.ALUop = alu; e.Zlowin = 1; e.Zhighin = md;
    return e;
  endfunction
  function automatic outs_t o_t5(input int ra, input bit md);
    outs_t e = '0;
    e.run = 1; e.Zlowout = 1;
    if (md) e.LOin = 1;
    else    e.Rin = 16'(1) << ra;
    return e;
  endfunction
  function automatic outs_t o_t6();
    outs_t e = '0;
    e.run = 1; e.Zhighout = 1; e.HIin = 1;
    return e;
  endfunction
  function automatic outs_t o_halted();
    outs_t e = '0;
    e.halted = 1;
    return e;
  endfunction

  task automatic check(input string tag);
    outs_t e;
    if (exp_q.size() == 0) begin
      errors++;
      $display("FAIL %s: scoreboard empty, got %h", tag, act);
    end else begin
      e = exp_q.pop_front();
      checks++;
      if (act !== e) begin
        errors++;
        $display("FAIL %s: got %h want %h", tag, act, e);
      end else begin
        $display("txn %s ok", tag);
      end
    end
  endtask

  // Drive one cycle of inputs, queue its expectation, compare at negedge
  task automatic step(input logic s, input logic mr, input logic [31:0] irv,
                      input outs_t e, input string tag);
    start = s; mem_ready = mr; ir = irv;
    exp_q.push_back(e);
    @(negedge clock);
    pcin_seen += int'(PCin);
    check(tag);
    @(posedge clock); #1;
  endtask

  task automatic do_clear(input string tag);
    clear = 1'b0;
    step(1'b0, 1'b0, 32'h0, o_zero(), tag);
    clear = 1'b1;
  endtask

  task automatic fetch(input logic [31:0] irv, input string tag);
    step(1'b0, 1'b1, irv, o_t0(), {tag, "_t0"});
    step(1'b0, 1'b1, irv, o_t1(1'b1), {tag, "_t1"});
    step(1'b0, 1'b1, irv, o_t2(), {tag, "_t2"});
  endtask

  // Append a full zero-wait instruction to the vector table
  task automatic add_inst(input logic [31:0] irv, input int ra, input int rb, input int rc,
                          input logic [3:0] alu, input bit md);
    vecs.push_back('{1'b0, 1'b1, irv, o_t0()});
    vecs.push_back('{1'b0, 1'b1, irv, o_t1(1'b1)});
    vecs.push_back('{1'b0, 1'b1, irv, o_t2()});
    vecs.push_back('{1'b1, 1'b1, irv, o_t3(rb)});
    vecs.push_back('{1'b0, 1'b1, irv, o_t4(rc, alu, md)});
    vecs.push_back('{1'b0, 1'b1, irv, o_t5(ra, md)});
    if (md) vecs.push_back('{1'b0, 1'b1, irv, o_t6()});
  endtask

  initial begin
    int          ops[11];
    logic [3:0]  alus[11];
    int          ra, rb, rc;
    logic [31:0] irv;
    bit          md;

    ops  = '{0, 1, 2, 3, 4, 5, 6, 7, 8, 15, 16};
    alus = '{4'd0, 4'd1, 4'd2, 4'd3, 4'd5, 4'd6, 4'd7, 4'd8, 4'd9, 4'd10, 4'd11};

    // Program table: start, shl R7,R0,R4, each ALU opcode, a NOP, a trailing fetch
    vecs.push_back('{1'b1, 1'b0, 32'h0, o_zero()});
    add_inst(32'h3382_0000, 7, 0, 4, 4'd7, 1'b0);
    for (int i = 0; i < 11; i++) begin
      ra  = (i * 3 + 1) % 16;
      rb  = (i * 5 + 2) % 16;
      rc  = (i * 7 + 3) % 16;
      irv = {5'(ops[i]), 4'(ra), 4'(rb), 4'(rc), 15'h0};
      md  = (ops[i] == 15) || (ops[i] == 16);
      add_inst(irv, ra, rb, rc, alus[i], md);
      if (i == 5) begin
        irv = {5'd25, 27'h0};
        vecs.push_back('{1'b0, 1'b1, irv, o_t0()});
        vecs.push_back('{1'b0, 1'b1, irv, o_t1(1'b1)});
        vecs.push_back('{1'b0, 1'b1, irv, o_t2()});
      end
    end
    vecs.push_back('{1'b0, 1'b1, 32'h0, o_t0()});
    vecs.push_back('{1'b0, 1'b0, 32'h0, o_t1(1'b0)});

    // Reset state
    @(posedge clock); #1;
    step(1'b1, 1'b1, 32'h0, o_zero(), "reset");
    clear = 1'b1;
    step(1'b0, 1'b1, 32'h0, o_zero(), "idle_hold");

    foreach (vecs[i]) step(vecs[i].s, vecs[i].mr, vecs[i].irv, vecs[i].e, $sformatf("vec%0d", i));

    // mul R3,R1 from the spec example
    do_clear("clr_mul");
    step(1'b1, 1'b0, 32'h0, o_zero(), "mul_start");
    fetch(32'h7818_8000, "mul");
    step(1'b0, 1'b0, 32'h7818_8000, o_t3(3), "mul_t3");
    step(1'b0, 1'b0, 32'h7818_8000, o_t4(1, 4'd10, 1'b1), "mul_t4");
    step(1'b0, 1'b0, 32'h7818_8000, o_t5(0, 1'b1), "mul_t5");
    step(1'b0, 1'b0, 32'h7818_8000, o_t6(), "mul_t6");
    step(1'b0, 1'b0, 32'h0, o_t0(), "mul_next_t0");

    // Two wait cycles in T1: PCin must strobe exactly once
    do_clear("clr_wait");
    step(1'b1, 1'b0, 32'h0, o_zero(), "wait_start");
    step(1'b0, 1'b0, 32'h0, o_t0(), "wait_t0");
    pcin_seen = 0;
    step(1'b0, 1'b0, 32'h0, o_t1(1'b0), "wait_t1a");
    step(1'b1, 1'b0, 32'h0, o_t1(1'b0), "wait_t1b");
    step(1'b0, 1'b1, 32'h0, o_t1(1'b1), "wait_t1c");
    step(1'b0, 1'b1, 32'h0, o_t2(), "wait_t2");
    checks++;
    if (pcin_seen != 1) begin
      errors++;
      $display("FAIL wait_pcin_count: got %0d want 1", pcin_seen);
    end
    step(1'b0, 1'b0, 32'h0, o_t3(0), "wait_t3");

    // HALT: sticky, start ignored
    do_clear("clr_halt");
    step(1'b1, 1'b0, 32'h0, o_zero(), "halt_start");
    fetch(32'hD000_0000, "halt");
    step(1'b1, 1'b1, 32'h0, o_halted(), "halted_a");
    step(1'b0, 1'b0, 32'h0, o_halted(), "halted_b");
    step(1'b1, 1'b0, 32'h0, o_halted(), "halted_c");

    // Clear asserted mid-T4, then IDLE until a fresh start
    do_clear("clr_t4");
    step(1'b1, 1'b0, 32'h0, o_zero(), "t4clr_start");
    fetch(32'h0891_8000, "t4clr");
    step(1'b0, 1'b0, 32'h0891_8000, o_t3(2), "t4clr_t3");
    clear = 1'b0;
    step(1'b0, 1'b0, 32'h0891_8000, o_zero(), "t4clr_asserted");
    clear = 1'b1;
    step(1'b0, 1'b1, 32'h0891_8000, o_zero(), "t4clr_idle_a");
    step(1'b0, 1'b1, 32'h0891_8000, o_zero(), "t4clr_idle_b");
    step(1'b1, 1'b0, 32'h0, o_zero(), "t4clr_restart");
    step(1'b0, 1'b0, 32'h0, o_t0(), "t4clr_t0");

    // Undefined opcode 31 goes straight back to fetch
    do_clear("clr_undef");
    step(1'b1, 1'b0, 32'h0, o_zero(), "undef_start");
    fetch(32'hF800_0000, "undef");
    step(1'b0, 1'b0, 32'hF800_0000, o_t0(), "undef_next_t0");
    step(1'b0, 1'b0, 32'hF800_0000, o_t1(1'b0), "undef_next_t1");

    if (exp_q.size() != 0) begin
      errors++;
      $display("FAIL scoreboard_drain: got %0d entries want 0", exp_q.size());
    end
    $display("CHECKS %0d ERRORS %0d", checks, errors);
    $finish;
  end

endmodule
